// File: rtl/fuzzy_pkg.sv
// rtl/fuzzy_pkg.sv - shared Q1.15 types and aggregator state encoding
// Contents: Q15_MAX, q15_t, agg_state_t {IDLE, ACC, DRAIN, OUT}.
package fuzzy_pkg;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;

    typedef logic [15:0] q15_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN,
        OUT
    } agg_state_t;

endpackage

// File: rtl/q15_sat_scale.sv
// rtl/q15_sat_scale.sv - converts wide accumulators to Q1.15 sums with clamp/optional ratio scaling
// Optional feature macro: RULE_AGG_RATIO_SCALE_EN
//   undefined: each sum clamped independently to Q15_MAX, sat = either clamped
//   defined:   both accumulators shifted right by the minimum k that brings acc_w <= Q15_MAX,
//              then S_wg clamped; sat = S_wg clamped
// Ports:
//   acc_w  in  ACC_W  sum of strengths
//   acc_wg in  ACC_W  sum of strength*singleton products
//   s_w    out 16     Q1.15 S_w
//   s_wg   out 16     Q1.15 S_wg
//   sat    out 1      a sum was clamped
module q15_sat_scale
    import fuzzy_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc_w,
    input  logic [ACC_W-1:0] acc_wg,
    output q15_t             s_w,
    output q15_t             s_wg,
    output logic             sat
);

    localparam logic [ACC_W-1:0] MAX_W = ACC_W'(Q15_MAX);

`ifdef RULE_AGG_RATIO_SCALE_EN
    localparam int SH_W = $clog2(ACC_W);

    logic [SH_W-1:0]  k;
    logic [ACC_W-1:0] w_sh;
    logic [ACC_W-1:0] wg_sh;
    logic             wg_ovf;

    // Highest set bit at or above bit 15 decides the shift; later (higher) hits win.
    always_comb begin
        k = '0;
        for (int i = 15; i < ACC_W; i++) begin
            if (acc_w[i]) k = SH_W'(i - 14);
        end
    end

    assign w_sh   = acc_w >> k;
    assign wg_sh  = acc_wg >> k;
    assign wg_ovf = wg_sh > MAX_W;
    // After the shift w_sh never exceeds MAX_W; the compare just keeps the form uniform.
    assign s_w    = (w_sh > MAX_W) ? Q15_MAX : w_sh[15:0];
    assign s_wg   = wg_ovf ? Q15_MAX : wg_sh[15:0];
    assign sat    = wg_ovf;
`else
    logic w_ovf;
    logic wg_ovf;

    assign w_ovf  = acc_w > MAX_W;
    assign wg_ovf = acc_wg > MAX_W;
    assign s_w    = w_ovf ? Q15_MAX : acc_w[15:0];
    assign s_wg   = wg_ovf ? Q15_MAX : acc_wg[15:0];
    assign sat    = w_ovf | wg_ovf;
`endif

endmodule

// File: rtl/rule_aggregator.sv
// rtl/rule_aggregator.sv - accumulates fired rules into Q1.15 S_w / S_wg frame sums for defuzz
// Optional feature macro: RULE_AGG_RATIO_SCALE_EN (ratio-preserving scaling, see q15_sat_scale)
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   rule_valid/ready/last       rule beat stream handshake and frame end
//   rule_w, rule_g              strength and singleton, unsigned Q1.15
//   S_w, S_wg                   held frame sums, Q1.15 saturated
//   out_valid, out_ready        output handshake
//   sat_flag                    a sum was clamped in the presented frame
//   err_len                     frame closed by hitting N_RULES beats without rule_last
module rule_aggregator
    import fuzzy_pkg::*;
#(
    parameter int N_RULES = 16,
    parameter int ACC_W   = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rule_valid,
    output logic        rule_ready,
    input  logic        rule_last,
    input  logic [15:0] rule_w,
    input  logic [15:0] rule_g,
    output logic [15:0] S_w,
    output logic [15:0] S_wg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sat_flag,
    output logic        err_len
);

    localparam int               CNT_W    = $clog2(N_RULES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_RULES - 1);

    agg_state_t       state;
    logic [CNT_W-1:0] beat_cnt;
    logic             frame_err;
    logic             drain_wait;

    logic             p1_valid;
    q15_t             p1_w;
    logic [ACC_W-1:0] p1_p;
    logic [ACC_W-1:0] acc_w;
    logic [ACC_W-1:0] acc_wg;

    logic [31:0]      prod_sh;
    logic             beat;
    logic             close;
    q15_t             sum_w;
    q15_t             sum_wg;
    logic             sum_sat;

    assign prod_sh = (32'(rule_w) * 32'(rule_g)) >> 15;
    assign beat    = rule_valid && rule_ready;
    assign close   = rule_last || (beat_cnt == LAST_CNT);

    q15_sat_scale #(.ACC_W(ACC_W)) u_sat (
        .acc_w  (acc_w),
        .acc_wg (acc_wg),
        .s_w    (sum_w),
        .s_wg   (sum_wg),
        .sat    (sum_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rule_ready <= 1'b0;
            beat_cnt   <= '0;
            frame_err  <= 1'b0;
            drain_wait <= 1'b0;
            p1_valid   <= 1'b0;
            p1_w       <= '0;
            p1_p       <= '0;
            acc_w      <= '0;
            acc_wg     <= '0;
            S_w        <= '0;
            S_wg       <= '0;
            out_valid  <= 1'b0;
            sat_flag   <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            // Stage 1: product and strength captured on acceptance.
            p1_valid <= beat;
            if (beat) begin
                p1_w <= rule_w;
                p1_p <= ACC_W'(prod_sh);
            end

            // Stage 2: accumulate. Never coincides with the post-handshake clear,
            // because no beat is accepted in DRAIN/OUT.
            if (p1_valid) begin
                acc_w  <= acc_w + ACC_W'(p1_w);
                acc_wg <= acc_wg + p1_p;
            end

            case (state)
                IDLE, ACC: begin
                    // Also raises rule_ready on the first cycle after reset.
                    rule_ready <= !(beat && close);
                    if (beat) begin
                        if (close) begin
                            state     <= DRAIN;
                            beat_cnt  <= '0;
                            frame_err <= !rule_last;
                        end else begin
                            state    <= ACC;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle lets stage 2 absorb the last beat.
                    drain_wait <= !drain_wait;
                    if (drain_wait) begin
                        S_w       <= sum_w;
                        S_wg      <= sum_wg;
                        sat_flag  <= sum_sat;
                        err_len   <= frame_err;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        rule_ready <= 1'b1;
                        acc_w      <= '0;
                        acc_wg     <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rule_aggregator.md
Name: rule_aggregator

Overview:
- Producer side of the defuzzifier interface: builds the Q1.15 sums S_w (sum of rule firing strengths) and S_wg (sum of strength × singleton output) that defuzz consumes.
- Accepts one fired rule per cycle over a valid/ready stream, framed by a last flag.
- Accumulates through a 2-stage pipeline, then presents the frame's sums on a held output with a valid/ready handshake.
- Sits between the rule-evaluation stage and defuzz.

Parameters:
- N_RULES, 16, maximum beats per frame; beat N_RULES is forced to be the frame's last beat.
- ACC_W, 24, accumulator width in bits; must be ≥ 16 + clog2(N_RULES).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rule_valid  in  1  rule beat valid
- rule_ready  out  1  aggregator can accept a beat
- rule_last  in  1  beat is the last of the frame
- rule_w  in  16  firing strength, unsigned Q1.15, range 0..32767
- rule_g  in  16  rule singleton output, unsigned Q1.15, range 0..32767
- S_w  out  16  frame sum of rule_w, Q1.15, saturated
- S_wg  out  16  frame sum of (rule_w*rule_g)>>15, Q1.15, saturated
- out_valid  out  1  S_w/S_wg hold a completed frame
- out_ready  in  1  consumer takes the frame
- sat_flag  out  1  at least one sum was clamped in the presented frame
- err_len  out  1  frame was terminated by N_RULES, not by rule_last

Behaviour:
- Reset (async assert, sync release):
  - S_w=0, S_wg=0, out_valid=0, sat_flag=0, err_len=0, rule_ready=0.
  - Accumulators, beat counter and pipeline valids are cleared; state=IDLE.
  - Reset mid-frame discards the frame; no partial output is ever presented.
- States:
  - IDLE: rule_ready=1. An accepted beat goes to ACC.
  - ACC: rule_ready=1. Accepting a beat with rule_last=1, or the N_RULES-th beat, goes to DRAIN.
  - DRAIN: rule_ready=0. Waits 1 cycle for stage 2, then loads the outputs and goes to OUT.
  - OUT: rule_ready=0, out_valid=1. When out_valid && out_ready, goes to IDLE, clears the accumulators and drops out_valid next cycle.
- Beat acceptance: a beat is accepted when rule_valid && rule_ready. The upstream must hold rule_w/rule_g/rule_last stable while rule_valid=1 && rule_ready=0.
- Pipeline:
  - Stage 1 registers p = (rule_w*rule_g)>>15 (32-bit product, truncated) and w.
  - Stage 2 adds both into ACC_W-bit accumulators. Accumulators never wrap (ACC_W sizing guarantees this).
- Latency: last beat accepted at edge t → out_valid=1 after edge t+2.
- Output formation: each sum is clamped to 16'h7FFF if its accumulator exceeds 32767. sat_flag=1 if either sum was clamped.
- Output hold: S_w, S_wg, sat_flag and err_len are stable while out_valid=1 and are held after the handshake until the next frame loads.
- Beat counter: counts accepted beats within the frame.
  - On the N_RULES-th beat with rule_last=0: frame closes, err_len=1 for that frame.
  - The next beat starts a new frame.
- Zero strength: w=0 beats are legal and contribute nothing.
- All-zero frame: sums 0/0 are presented as-is; the consumer handles the epsilon case.

Optional Feature:
- Macro: RULE_AGG_RATIO_SCALE_EN.
- Defined:
  - In DRAIN, if the S_w accumulator > 32767, both accumulators are right-shifted by the same amount k, the minimum k that brings S_w ≤ 32767. This is a combinational priority encoder over bits [ACC_W-1:15].
  - The S_wg/S_w ratio is preserved up to truncation. S_wg is still clamped if it exceeds 32767 after the shift.
  - sat_flag=1 only when S_wg is clamped after scaling.
- Undefined: plain independent saturation as above. No extra logic.

Decomposition:
- Package fuzzy_pkg:
  - Q15_MAX=16'h7FFF.
  - typedef q15_t (logic [15:0]).
  - enum agg_state_t {IDLE, ACC, DRAIN, OUT}.
- Sub-module q15_sat_scale: accumulators in, 16-bit sums plus sat out, containing the optional scaling logic. Natural split; reused by later aggregation variants.

Test Plan:
- Reset/idle: hold rst_n=0 with random inputs → S_w=0, S_wg=0, out_valid=0, rule_ready=0. After release, rule_ready=1.
- Single rule, w=16384, g=16384, last=1 at edge t → out_valid at t+2 with S_w=16384, S_wg=8192, sat_flag=0. Feeding defuzz gives G=50.
- Two rules, (w=20000, g=0) then (w=10000, g=32767, last) → S_w=30000, S_wg=9999, sat_flag=0. Hold out_ready=0 for 5 cycles → outputs stable and rule_ready=0 throughout.
- Overflow, (w=32767, g=32767)×2:
  - Macro undefined → S_w=32767, S_wg=32767, sat_flag=1.
  - Macro defined → S_w=32767, S_wg=32766, sat_flag=0.
- Length error: N_RULES beats of w=1000, g=32767, all with last=0 → frame closes on beat 16 with S_w=16000, S_wg=15984, err_len=1. The next frame presents err_len=0.
- Reset mid-frame: 3 beats accepted, then rst_n pulsed low → no out_valid. A fresh single-rule frame gives the correct sums.
